// File: rtl/video_timing_ctrl_if.sv
// video_timing_ctrl_if
//   Pixel-source handshake plus native video output bus of the raster
//   timing controller.
//   master : controller side (drives data_req and the video bus, reads pixels)
//   slave  : environment side (drives pixel_in/pixel_vld, reads the video bus)
//   data_req    pixel wanted this cycle; pixel_in sampled on the same edge
//   pixel_in    pixel from source
//   pixel_vld   pixel_in valid
//   vsync/hsync sync pulses, polarity from the shadowed hs_pol/vs_pol
//   de/blank    active video / its complement (blank=1 while idle)
//   field       odd/even frame tag
//   data        output pixel, 0 outside de
//   frame_start one-cycle pulse on the first de cycle of each frame
interface video_timing_ctrl_if #(
  parameter int DSIZE = 24
);
  logic             data_req;
  logic [DSIZE-1:0] pixel_in;
  logic             pixel_vld;
  logic             vsync;
  logic             hsync;
  logic             de;
  logic             blank;
  logic             field;
  logic [DSIZE-1:0] data;
  logic             frame_start;

  modport master (
    output data_req, vsync, hsync, de, blank, field, data, frame_start,
    input  pixel_in, pixel_vld
  );

  modport slave (
    input  data_req, vsync, hsync, de, blank, field, data, frame_start,
    output pixel_in, pixel_vld
  );
endinterface

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
//   Programmable raster timing controller between the VDMA pixel FIFO and the
//   video output port. Timing and polarity inputs are shadowed on start and
//   at every frame wrap, so mid-frame changes only take effect next frame.
//   i_pclk        pixel clock
//   i_prst        synchronous active-high reset
//   i_enable      1 = run raster, 0 = stop after the current frame
//   i_h_*/i_v_*   active/front porch/sync/back porch lengths (each >= 1)
//   i_hs_pol      1 = hsync active-high
//   i_vs_pol      1 = vsync active-high
//   vid           pixel handshake and video bus (master side)
//   o_busy        1 while rastering
//   o_underflow   sticky: pixel requested while source not valid
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | outputs parked (blank=1, syncs inactive), waiting for enable
// ST_RUN  | counters sweep the raster; stop only at a frame wrap
module video_timing_ctrl #(
  parameter int DSIZE = 24,
  parameter int CW    = 12
) (
  input  logic                i_pclk,
  input  logic                i_prst,
  input  logic                i_enable,
  input  logic [CW-1:0]       i_h_active,
  input  logic [CW-1:0]       i_h_fp,
  input  logic [CW-1:0]       i_h_sync,
  input  logic [CW-1:0]       i_h_bp,
  input  logic [CW-1:0]       i_v_active,
  input  logic [CW-1:0]       i_v_fp,
  input  logic [CW-1:0]       i_v_sync,
  input  logic [CW-1:0]       i_v_bp,
  input  logic                i_hs_pol,
  input  logic                i_vs_pol,
  video_timing_ctrl_if.master vid,
  output logic                o_busy,
  output logic                o_underflow
);
  // Counters share the width of the totals: a line of four maximal fields
  // is longer than a CW-bit counter could reach.
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_hcnt, r_vcnt;
  logic [CW-1:0]    r_h_active, r_h_fp, r_h_sync, r_h_bp;
  logic [CW-1:0]    r_v_active, r_v_fp, r_v_sync, r_v_bp;
  logic             r_hs_pol, r_vs_pol;
  logic             r_vsync, r_hsync, r_de, r_blank, r_field, r_frame_start;
  logic [DSIZE-1:0] r_data;
  logic             r_underflow;

  logic [SW-1:0] w_hs_start, w_hs_end, w_ht;
  logic [SW-1:0] w_vs_start, w_vs_end, w_vt;
  logic          w_req, w_hs_on, w_vs_on, w_h_last, w_v_last, w_wrap, w_load;
  logic          w_first;

  assign w_hs_start = {2'b00, r_h_active} + {2'b00, r_h_fp};
  assign w_hs_end   = w_hs_start + {2'b00, r_h_sync};
  assign w_ht       = w_hs_end + {2'b00, r_h_bp};
  assign w_vs_start = {2'b00, r_v_active} + {2'b00, r_v_fp};
  assign w_vs_end   = w_vs_start + {2'b00, r_v_sync};
  assign w_vt       = w_vs_end + {2'b00, r_v_bp};

  // Request depends on registers only, so the source sees no input-to-output path.
  assign w_req    = (r_state == ST_RUN) && (r_hcnt < {2'b00, r_h_active})
                    && (r_vcnt < {2'b00, r_v_active});
  assign w_hs_on  = (r_hcnt >= w_hs_start) && (r_hcnt < w_hs_end);
  assign w_vs_on  = (r_vcnt >= w_vs_start) && (r_vcnt < w_vs_end);
  assign w_h_last = (r_hcnt == w_ht - ONE);
  assign w_v_last = (r_vcnt == w_vt - ONE);
  assign w_wrap   = (r_state == ST_RUN) && w_h_last && w_v_last;
  assign w_load   = i_enable && ((r_state == ST_IDLE) || w_wrap);
  assign w_first  = w_req && (r_hcnt == '0) && (r_vcnt == '0);

  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      r_state       <= ST_IDLE;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_h_active    <= '0;
      r_h_fp        <= '0;
      r_h_sync      <= '0;
      r_h_bp        <= '0;
      r_v_active    <= '0;
      r_v_fp        <= '0;
      r_v_sync      <= '0;
      r_v_bp        <= '0;
      r_hs_pol      <= 1'b1;
      r_vs_pol      <= 1'b1;
      r_vsync       <= 1'b0;
      r_hsync       <= 1'b0;
      r_de          <= 1'b0;
      r_blank       <= 1'b1;
      r_field       <= 1'b0;
      r_data        <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_h_active <= i_h_active;
        r_h_fp     <= i_h_fp;
        r_h_sync   <= i_h_sync;
        r_h_bp     <= i_h_bp;
        r_v_active <= i_v_active;
        r_v_fp     <= i_v_fp;
        r_v_sync   <= i_v_sync;
        r_v_bp     <= i_v_bp;
        r_hs_pol   <= i_hs_pol;
        r_vs_pol   <= i_vs_pol;
      end

      case (r_state)
        ST_IDLE: begin
          r_hcnt        <= '0;
          r_vcnt        <= '0;
          r_hsync       <= ~r_hs_pol;
          r_vsync       <= ~r_vs_pol;
          r_de          <= 1'b0;
          r_blank       <= 1'b1;
          r_data        <= '0;
          r_frame_start <= 1'b0;
          if (i_enable) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_h_last) begin
            r_hcnt <= '0;
            if (w_v_last) begin
              r_vcnt <= '0;
              // Stop is honoured only here, so a frame is never cut short.
              if (!i_enable) r_state <= ST_IDLE;
            end else begin
              r_vcnt <= r_vcnt + ONE;
            end
          end else begin
            r_hcnt <= r_hcnt + ONE;
          end
          // Registered outputs reflect the counter position of this cycle.
          r_de          <= w_req;
          r_blank       <= ~w_req;
          r_hsync       <= w_hs_on ? r_hs_pol : ~r_hs_pol;
          r_vsync       <= w_vs_on ? r_vs_pol : ~r_vs_pol;
          r_data        <= (w_req && vid.pixel_vld) ? vid.pixel_in : '0;
          r_frame_start <= w_first;
          if (w_first) r_field <= ~r_field;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Missing pixels are flagged, never waited for: raster timing is fixed.
      if (w_req && !vid.pixel_vld) r_underflow <= 1'b1;
    end
  end

  assign vid.data_req    = w_req;
  assign vid.vsync       = r_vsync;
  assign vid.hsync       = r_hsync;
  assign vid.de          = r_de;
  assign vid.blank       = r_blank;
  assign vid.field       = r_field;
  assign vid.data        = r_data;
  assign vid.frame_start = r_frame_start;
  assign o_busy          = (r_state == ST_RUN);
  assign o_underflow     = r_underflow;
endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl
//   Directed bench for video_timing_ctrl: 4/1/2/1 x 3/1/1/1 raster (48-cycle
//   frame), mid-frame width change, stop at frame end, underflow, polarity
//   change and mid-line reset.
module tb_video_timing_ctrl;
  localparam int DSIZE = 24;
  localparam int CW    = 12;

  logic          clk = 1'b0;
  logic          prst, enable;
  logic [CW-1:0] h_active, h_fp, h_sync, h_bp;
  logic [CW-1:0] v_active, v_fp, v_sync, v_bp;
  logic          hs_pol, vs_pol, busy, underflow;

  video_timing_ctrl_if #(.DSIZE(DSIZE)) vif ();

  video_timing_ctrl #(.DSIZE(DSIZE), .CW(CW)) dut (
    .i_pclk      (clk),
    .i_prst      (prst),
    .i_enable    (enable),
    .i_h_active  (h_active),
    .i_h_fp      (h_fp),
    .i_h_sync    (h_sync),
    .i_h_bp      (h_bp),
    .i_v_active  (v_active),
    .i_v_fp      (v_fp),
    .i_v_sync    (v_sync),
    .i_v_bp      (v_bp),
    .i_hs_pol    (hs_pol),
    .i_vs_pol    (vs_pol),
    .vid         (vif.master),
    .o_busy      (busy),
    .o_underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int fs_q[$], fld_q[$], de_q[$], hs_q[$], vs_q[$];
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  bit mon_data = 1'b1;
  int exp_seq  = 'h100;
  int data_err = 0;
  int src_seq  = 'h100;
  bit req_q, vld_q;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    else n_pass++;
  endtask

  // Per-frame statistics; each push at a frame_start closes the previous frame.
  always @(negedge clk) begin
    cyc++;
    if (vif.frame_start) begin
      fs_q.push_back(cyc);
      fld_q.push_back(int'(vif.field));
      de_q.push_back(de_cnt);
      hs_q.push_back(hs_cnt);
      vs_q.push_back(vs_cnt);
      de_cnt = 0;
      hs_cnt = 0;
      vs_cnt = 0;
    end
    if (vif.de) begin
      de_cnt++;
      if (mon_data) begin
        if (int'(vif.data) != exp_seq) data_err++;
        exp_seq++;
      end
    end
    if (vif.hsync) hs_cnt++;
    if (vif.vsync) vs_cnt++;
  end

  // One cycle; the source advances only when its pixel was taken.
  task automatic step();
    req_q = vif.data_req;
    vld_q = vif.pixel_vld;
    @(negedge clk);
    #1;
    if (req_q && vld_q) src_seq++;
    vif.pixel_in = 24'(src_seq);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 300 && fs_q.size() < target; i++) step();
    check_val("frames_seen", 32'(fs_q.size() >= target), 32'd1);
  endtask

  int b, f0, v, prev_hs, got;

  initial begin
    prst = 1'b1; enable = 1'b0;
    h_active = 12'd4; h_fp = 12'd1; h_sync = 12'd2; h_bp = 12'd1;
    v_active = 12'd3; v_fp = 12'd1; v_sync = 12'd1; v_bp = 12'd1;
    hs_pol = 1'b1; vs_pol = 1'b1;
    vif.pixel_in = 24'h000100; vif.pixel_vld = 1'b1;
    repeat (3) step();

    // reset values
    check_val("rst_vsync", 32'(vif.vsync), 0);
    check_val("rst_hsync", 32'(vif.hsync), 0);
    check_val("rst_de", 32'(vif.de), 0);
    check_val("rst_req", 32'(vif.data_req), 0);
    check_val("rst_field", 32'(vif.field), 0);
    check_val("rst_fs", 32'(vif.frame_start), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_uflow", 32'(underflow), 0);
    check_val("rst_blank", 32'(vif.blank), 1);
    check_val("rst_data", 32'(vif.data), 0);
    prst = 1'b0;
    repeat (2) step();
    check_val("idle_busy", 32'(busy), 0);
    check_val("idle_blank", 32'(vif.blank), 1);

    // first frame: request right after start, de one cycle later
    enable = 1'b1;
    step();
    check_val("start_busy", 32'(busy), 1);
    check_val("start_req", 32'(vif.data_req), 1);
    check_val("start_de_lag", 32'(vif.de), 0);
    step();
    check_val("first_de", 32'(vif.de), 1);
    check_val("first_fs", 32'(vif.frame_start), 1);
    check_val("first_field", 32'(vif.field), 1);
    check_val("first_data", 32'(vif.data), 32'h100);
    repeat (4) step();
    check_val("fp_de", 32'(vif.de), 0);
    check_val("fp_hsync", 32'(vif.hsync), 0);
    step();
    check_val("hs_start", 32'(vif.hsync), 1);
    step();
    check_val("hs_end", 32'(vif.hsync), 1);
    step();
    check_val("bp_hsync", 32'(vif.hsync), 0);

    wait_frames(3);
    if (fs_q.size() >= 3) begin
      check_val("period_1", 32'(fs_q[1] - fs_q[0]), 48);
      check_val("period_2", 32'(fs_q[2] - fs_q[1]), 48);
      check_val("field_2", 32'(fld_q[1]), 0);
      check_val("field_3", 32'(fld_q[2]), 1);
      check_val("de_per_frame", 32'(de_q[1]), 12);
      check_val("de_per_frame2", 32'(de_q[2]), 12);
      check_val("hs_per_frame", 32'(hs_q[1]), 12);
      check_val("vs_per_frame", 32'(vs_q[1]), 8);
    end

    // h_active 4->6 mid-frame: current frame unchanged, next is HT=10
    b = fs_q.size();
    h_active = 12'd6;
    wait_frames(b + 2);
    if (fs_q.size() >= b + 2) begin
      check_val("chg_cur_de", 32'(de_q[b]), 12);
      check_val("chg_cur_per", 32'(fs_q[b] - fs_q[b-1]), 48);
      check_val("chg_next_de", 32'(de_q[b+1]), 18);
      check_val("chg_next_per", 32'(fs_q[b+1] - fs_q[b]), 60);
    end

    // back to HT=8, then drop enable 20 cycles into that frame
    b = fs_q.size();
    h_active = 12'd4;
    wait_frames(b + 1);
    f0 = fs_q[fs_q.size() - 1];
    repeat (19) step();
    enable = 1'b0;
    for (int i = 0; i < 100 && busy; i++) step();
    check_val("stop_len", 32'(cyc - f0), 47);
    check_val("stop_de", 32'(de_cnt), 12);
    repeat (2) step();
    check_val("stop_busy", 32'(busy), 0);
    check_val("stop_blank", 32'(vif.blank), 1);
    check_val("stop_hsync", 32'(vif.hsync), 0);
    check_val("stop_vsync", 32'(vif.vsync), 0);
    check_val("stop_req", 32'(vif.data_req), 0);
    check_val("stop_no_fs", 32'(fs_q.size()), 32'(b + 1));
    check_val("data_seq", 32'(data_err), 0);

    // underflow on one request cycle
    mon_data = 1'b0;
    check_val("pre_uflow", 32'(underflow), 0);
    enable = 1'b1;
    step();
    vif.pixel_vld = 1'b0;
    step();
    check_val("uf_de", 32'(vif.de), 1);
    check_val("uf_data", 32'(vif.data), 0);
    check_val("uf_flag", 32'(underflow), 1);
    vif.pixel_vld = 1'b1;
    v = src_seq;
    step();
    check_val("uf_next_data", 32'(vif.data), 32'(v));
    repeat (4) step();
    check_val("uf_sticky", 32'(underflow), 1);

    // active-low syncs from the next frame, then reset mid-line
    hs_pol = 1'b0;
    vs_pol = 1'b0;
    prev_hs = 0;
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      prev_hs = int'(vif.hsync);
      step();
      got = int'(vif.frame_start);
    end
    check_val("pol_fs_seen", 32'(got), 1);
    check_val("pol_old_hs", 32'(prev_hs), 0);
    check_val("pol_new_hs", 32'(vif.hsync), 1);
    check_val("pol_new_vs", 32'(vif.vsync), 1);
    repeat (5) step();
    check_val("pol_hs_active", 32'(vif.hsync), 0);

    prst = 1'b1;
    step();
    check_val("mrst_busy", 32'(busy), 0);
    check_val("mrst_de", 32'(vif.de), 0);
    check_val("mrst_req", 32'(vif.data_req), 0);
    check_val("mrst_hsync", 32'(vif.hsync), 0);
    check_val("mrst_vsync", 32'(vif.vsync), 0);
    check_val("mrst_blank", 32'(vif.blank), 1);
    check_val("mrst_uflow", 32'(underflow), 0);
    check_val("mrst_field", 32'(vif.field), 0);
    check_val("mrst_data", 32'(vif.data), 0);
    prst = 1'b0;
    step();
    check_val("restart_req", 32'(vif.data_req), 1);
    check_val("restart_busy", 32'(busy), 1);
    step();
    check_val("restart_de", 32'(vif.de), 1);
    check_val("restart_fs", 32'(vif.frame_start), 1);
    check_val("restart_field", 32'(vif.field), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
